// File: rtl/fpu_issue_ctrl.sv
// EX-stage sequencer for the float unit: holds opcode/operands while the pipeline
// stalls for the instruction latency, then presents the captured result as a one-cycle pulse.
module fpu_issue_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              issue_valid,
    input  logic [4:0]        fpu_cont_in,
    input  logic [CNT_W-1:0]  fpu_stall_in,
    input  logic [4:0]        rd_in,
    input  logic [DATA_W-1:0] x1_in,
    input  logic [DATA_W-1:0] x2_in,
    input  logic              flush,
    input  logic [DATA_W-1:0] fpu_y,
    output logic [4:0]        fpu_cont_out,
    output logic [DATA_W-1:0] x1_out,
    output logic [DATA_W-1:0] x2_out,
    output logic              stall_out,
    output logic              busy,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic [4:0]        wb_rd
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [4:0]          cont_q, cont_d;
    logic [4:0]          rd_q, rd_d;
    logic [DATA_W-1:0]   x1_q, x1_d;
    logic [DATA_W-1:0]   x2_q, x2_d;
    logic                wb_valid_q, wb_valid_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic [4:0]          wb_rd_q, wb_rd_d;
    logic                stall_s;

    // State and held-copy registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cnt_q      <= CNT_ZERO;
            cont_q     <= 5'd0;
            rd_q       <= 5'd0;
            x1_q       <= {DATA_W{1'b0}};
            x2_q       <= {DATA_W{1'b0}};
            wb_valid_q <= 1'b0;
            wb_data_q  <= {DATA_W{1'b0}};
            wb_rd_q    <= 5'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cont_q     <= cont_d;
            rd_q       <= rd_d;
            x1_q       <= x1_d;
            x2_q       <= x2_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
        end
    end

    // Next-state, capture and stall decision
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cont_d     = cont_q;
        rd_d       = rd_q;
        x1_d       = x1_q;
        x2_d       = x2_q;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        stall_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue_valid && !flush) begin
                    cont_d = fpu_cont_in;
                    rd_d   = rd_in;
                    x1_d   = x1_in;
                    x2_d   = x2_in;
                    cnt_d  = fpu_stall_in;
                    if (fpu_stall_in == CNT_ZERO) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = fpu_y;
                        wb_rd_d    = rd_in;
                    end else begin
                        state_d = WAIT;
                        stall_s = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                // Flush beats completion, even on the final count.
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_ONE) begin
                    state_d    = IDLE;
                    cnt_d      = CNT_ZERO;
                    wb_valid_d = 1'b1;
                    wb_data_d  = fpu_y;
                    wb_rd_d    = rd_q;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                    stall_s = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Operand path: pass-through when idle, held copies while waiting
    always_comb begin
        if (state_q == WAIT) begin
            fpu_cont_out = cont_q;
            x1_out       = x1_q;
            x2_out       = x2_q;
        end else begin
            fpu_cont_out = fpu_cont_in;
            x1_out       = x1_in;
            x2_out       = x2_in;
        end
    end

    assign stall_out = stall_s && !flush;
    assign busy      = (state_q == WAIT);
    assign wb_valid  = wb_valid_q;
    assign wb_data   = wb_data_q;
    assign wb_rd     = wb_rd_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: latency/stall sequencing, flush, back-to-back and async reset.
module tb_fpu_issue_ctrl;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rstn;
    logic              issue_valid;
    logic [4:0]        fpu_cont_in;
    logic [CNT_W-1:0]  fpu_stall_in;
    logic [4:0]        rd_in;
    logic [DATA_W-1:0] x1_in;
    logic [DATA_W-1:0] x2_in;
    logic              flush;
    logic [DATA_W-1:0] fpu_y;
    logic [4:0]        fpu_cont_out;
    logic [DATA_W-1:0] x1_out;
    logic [DATA_W-1:0] x2_out;
    logic              stall_out;
    logic              busy;
    logic              wb_valid;
    logic [DATA_W-1:0] wb_data;
    logic [4:0]        wb_rd;

    int n_checks = 0;
    int n_fail   = 0;

    fpu_issue_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .issue_valid(issue_valid), .fpu_cont_in(fpu_cont_in),
        .fpu_stall_in(fpu_stall_in), .rd_in(rd_in), .x1_in(x1_in), .x2_in(x2_in),
        .flush(flush), .fpu_y(fpu_y), .fpu_cont_out(fpu_cont_out), .x1_out(x1_out),
        .x2_out(x2_out), .stall_out(stall_out), .busy(busy), .wb_valid(wb_valid),
        .wb_data(wb_data), .wb_rd(wb_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; issue_valid = 1'b0; fpu_cont_in = 5'b10101; fpu_stall_in = 4'd0;
        rd_in = 5'd0; x1_in = 32'hA5A5A5A5; x2_in = 32'h5A5A5A5A; flush = 1'b0; fpu_y = 32'h0;
        tick(); tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", stall_out); end
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid got %b exp 0", wb_valid); end
        n_checks++; if (wb_data !== 32'h0) begin n_fail++; $display("FAIL reset_wb_data got %h exp 0", wb_data); end
        n_checks++; if (wb_rd !== 5'd0) begin n_fail++; $display("FAIL reset_wb_rd got %0d exp 0", wb_rd); end
        n_checks++; if (fpu_cont_out !== 5'b10101 || x1_out !== 32'hA5A5A5A5 || x2_out !== 32'h5A5A5A5A) begin
            n_fail++; $display("FAIL reset_passthru got %b/%h/%h exp 10101/a5a5a5a5/5a5a5a5a", fpu_cont_out, x1_out, x2_out);
        end
        #2 rstn = 1'b1;
        tick();
    endtask

    // fadd with latency 4; returns after the capture edge, issue_valid dropped
    task automatic test_fadd(input logic [4:0] rd, input logic check_prev_zero);
        int stalls = 0;
        issue_valid = 1'b1; flush = 1'b0; fpu_cont_in = 5'b10000; fpu_stall_in = 4'd4;
        rd_in = rd; x1_in = 32'h3F800000; x2_in = 32'h40000000; fpu_y = 32'hDEADBEEF;
        #2;
        n_checks++; if (stall_out !== 1'b1) begin n_fail++; $display("FAIL fadd_accept_stall got %b exp 1", stall_out); end
        if (stall_out === 1'b1) stalls++;
        tick();
        for (int i = 1; i <= 4; i++) begin
            fpu_cont_in = 5'b00000; x1_in = x1_in ^ 32'hFFFF0000; x2_in = 32'h0; rd_in = 5'd31;
            fpu_stall_in = 4'd0;
            fpu_y = (i == 4) ? 32'h40400000 : 32'hDEADBEEF;
            #2;
            n_checks++; if (stall_out !== (i < 4)) begin n_fail++; $display("FAIL fadd_wait_stall cyc %0d got %b exp %b", i, stall_out, (i < 4)); end
            if (stall_out === 1'b1) stalls++;
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fadd_busy cyc %0d got %b exp 1", i, busy); end
            n_checks++; if (fpu_cont_out !== 5'b10000 || x1_out !== 32'h3F800000 || x2_out !== 32'h40000000) begin
                n_fail++; $display("FAIL fadd_hold cyc %0d got %b/%h/%h", i, fpu_cont_out, x1_out, x2_out);
            end
            n_checks++; if (wb_valid !== 1'b0 && !(i == 1 && !check_prev_zero)) begin n_fail++; $display("FAIL fadd_early_wb cyc %0d got %b exp 0", i, wb_valid); end
            tick();
        end
        issue_valid = 1'b0;
        n_checks++; if (stalls != 4) begin n_fail++; $display("FAIL fadd_stall_count got %0d exp 4", stalls); end
        n_checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h40400000 || wb_rd !== rd) begin
            n_fail++; $display("FAIL fadd_wb got v=%b d=%h rd=%0d exp 1/40400000/%0d", wb_valid, wb_data, wb_rd, rd);
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fadd_idle got %b exp 0", busy); end
        tick();
        n_checks++; if (wb_valid !== 1'b0 || wb_data !== 32'h40400000) begin
            n_fail++; $display("FAIL fadd_pulse_end got v=%b d=%h exp 0/40400000", wb_valid, wb_data);
        end
    endtask

    task automatic test_zero_latency();
        issue_valid = 1'b1; fpu_cont_in = 5'b11000; fpu_stall_in = 4'd0; rd_in = 5'd7;
        x1_in = 32'h1; x2_in = 32'h2; fpu_y = 32'hBF800000;
        #2;
        n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL fsgnj_stall got %b exp 0", stall_out); end
        tick();
        issue_valid = 1'b0; fpu_y = 32'h0;
        n_checks++; if (wb_valid !== 1'b1 || wb_data !== 32'hBF800000 || wb_rd !== 5'd7 || busy !== 1'b0) begin
            n_fail++; $display("FAIL fsgnj_wb got v=%b d=%h rd=%0d busy=%b exp 1/bf800000/7/0", wb_valid, wb_data, wb_rd, busy);
        end
        tick();
        n_checks++; if (wb_valid !== 1'b0 || wb_data !== 32'hBF800000) begin
            n_fail++; $display("FAIL fsgnj_hold got v=%b d=%h exp 0/bf800000", wb_valid, wb_data);
        end
    endtask

    task automatic test_flush_wait();
        issue_valid = 1'b1; fpu_cont_in = 5'b10011; fpu_stall_in = 4'd6; rd_in = 5'd5;
        x1_in = 32'h40C00000; x2_in = 32'h40000000; fpu_y = 32'h40400000;
        tick();
        for (int i = 1; i <= 3; i++) begin
            flush = (i == 3);
            #2;
            n_checks++; if (stall_out !== (i != 3) || busy !== 1'b1) begin
                n_fail++; $display("FAIL fdiv_stall cyc %0d got s=%b b=%b exp %b/1", i, stall_out, busy, (i != 3));
            end
            tick();
        end
        flush = 1'b0; issue_valid = 1'b0;
        n_checks++; if (busy !== 1'b0 || wb_valid !== 1'b0 || wb_data !== 32'hBF800000 || wb_rd !== 5'd7) begin
            n_fail++; $display("FAIL fdiv_flush got b=%b v=%b d=%h rd=%0d exp 0/0/bf800000/7", busy, wb_valid, wb_data, wb_rd);
        end
        tick();
        n_checks++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL fdiv_after got v=%b b=%b exp 0/0", wb_valid, busy); end
    endtask

    task automatic test_back_to_back();
        int stalls = 0;
        int p0 = -1;
        int p1 = -1;
        for (int c = 0; c <= 7; c++) begin
            if (c <= 4) begin
                issue_valid = 1'b1; fpu_cont_in = 5'b10010; fpu_stall_in = 4'd4; rd_in = 5'd1;
                fpu_y = 32'h11111111;
            end else if (c <= 6) begin
                issue_valid = 1'b1; fpu_cont_in = 5'b11100; fpu_stall_in = 4'd1; rd_in = 5'd2;
                fpu_y = 32'h22222222;
            end else begin
                issue_valid = 1'b0; fpu_y = 32'h0;
            end
            #2;
            if (stall_out === 1'b1) stalls++;
            tick();
            if (wb_valid === 1'b1) begin
                if (p0 < 0) begin
                    p0 = c;
                    n_checks++; if (wb_data !== 32'h11111111 || wb_rd !== 5'd1) begin
                        n_fail++; $display("FAIL b2b_first got d=%h rd=%0d exp 11111111/1", wb_data, wb_rd);
                    end
                end else if (p1 < 0) begin
                    p1 = c;
                    n_checks++; if (wb_data !== 32'h22222222 || wb_rd !== 5'd2) begin
                        n_fail++; $display("FAIL b2b_second got d=%h rd=%0d exp 22222222/2", wb_data, wb_rd);
                    end
                end else begin
                    n_checks++; n_fail++; $display("FAIL b2b_extra_pulse at cyc %0d", c);
                end
            end
        end
        n_checks++; if (stalls != 5) begin n_fail++; $display("FAIL b2b_stalls got %0d exp 5", stalls); end
        n_checks++; if (p0 != 4 || p1 != 6) begin n_fail++; $display("FAIL b2b_pulse_pos got %0d,%0d exp 4,6", p0, p1); end
    endtask

    task automatic test_async_reset();
        issue_valid = 1'b1; fpu_cont_in = 5'b10110; fpu_stall_in = 4'd2; rd_in = 5'd4;
        x1_in = 32'h40800000; x2_in = 32'h0; fpu_y = 32'h40000000;
        tick();
        #2;
        n_checks++; if (busy !== 1'b1 || stall_out !== 1'b1) begin n_fail++; $display("FAIL fsqrt_wait got b=%b s=%b exp 1/1", busy, stall_out); end
        rstn = 1'b0; issue_valid = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || stall_out !== 1'b0 || wb_valid !== 1'b0 || wb_data !== 32'h0) begin
            n_fail++; $display("FAIL areset got b=%b s=%b v=%b d=%h exp 0/0/0/0", busy, stall_out, wb_valid, wb_data);
        end
        tick(); tick();
        n_checks++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL areset_hold got v=%b b=%b exp 0/0", wb_valid, busy); end
        #2 rstn = 1'b1;
        tick();
        test_fadd(5'd3, 1'b1);
    endtask

    task automatic test_flush_last();
        issue_valid = 1'b1; flush = 1'b1; fpu_cont_in = 5'b10000; fpu_stall_in = 4'd3; rd_in = 5'd9;
        #2;
        n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL idle_flush_stall got %b exp 0", stall_out); end
        tick();
        n_checks++; if (busy !== 1'b0 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL idle_flush_block got b=%b v=%b exp 0/0", busy, wb_valid); end
        flush = 1'b0; fpu_stall_in = 4'd4; rd_in = 5'd6; fpu_y = 32'h12345678;
        tick();
        for (int i = 1; i <= 4; i++) begin
            flush = (i == 4);
            #2;
            n_checks++; if (stall_out !== (i < 4) || busy !== 1'b1) begin
                n_fail++; $display("FAIL flast_stall cyc %0d got s=%b b=%b exp %b/1", i, stall_out, busy, (i < 4));
            end
            tick();
        end
        flush = 1'b0; issue_valid = 1'b0;
        n_checks++; if (wb_valid !== 1'b0 || busy !== 1'b0 || wb_data !== 32'h40400000 || wb_rd !== 5'd3) begin
            n_fail++; $display("FAIL flast_result got v=%b b=%b d=%h rd=%0d exp 0/0/40400000/3", wb_valid, busy, wb_data, wb_rd);
        end
    endtask

    initial begin
        test_reset();
        test_fadd(5'd3, 1'b1);
        test_zero_latency();
        test_flush_wait();
        test_back_to_back();
        test_async_reset();
        test_flush_last();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Sequencer between the decode stage and the fpu block.
- Consumes the per-instruction fpu_stall latency and fpu_cont opcode from the controller. Holds the opcode and operands stable at the fpu inputs while the pipeline is stalled for the instruction's latency.
- Captures the selected fpu result and presents it for write-back as a one-cycle pulse.
- Sits in the EX stage and drives the global pipeline stall for multi-cycle float ops.

Parameters:
DATA_W, 32, operand/result width
CNT_W, 4, width of latency count (matches fpu_stall)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
issue_valid  in  1  EX holds a valid float-unit instruction this cycle
fpu_cont_in  in  5  opcode from controller (10000 fadd ... 11101 fcvtws)
fpu_stall_in  in  CNT_W  latency from controller (0,1,2,4,6)
rd_in  in  5  destination register index
x1_in  in  DATA_W  operand 1 (after forwarding)
x2_in  in  DATA_W  operand 2 (after forwarding)
flush  in  1  kill in-flight instruction (branch/jump redirect)
fpu_y  in  DATA_W  result from fpu mux
fpu_cont_out  out  5  opcode to fpu
x1_out  out  DATA_W  operand 1 to fpu
x2_out  out  DATA_W  operand 2 to fpu
stall_out  out  1  freeze IF/ID/EX registers
busy  out  1  state is WAIT
wb_valid  out  1  one-cycle pulse: wb_data/wb_rd valid
wb_data  out  DATA_W  captured result
wb_rd  out  5  destination of captured result

Behaviour:
- Reset (rstn low, async): state IDLE, cnt 0; all held registers 0; wb_valid 0, wb_data 0, wb_rd 0.
  - Outputs then follow the IDLE pass-through rules below, so stall_out is 0 while issue_valid is low.
- States:
  - IDLE: accepting.
  - WAIT: counting down latency.
- Output muxing:
  - In IDLE: fpu_cont_out/x1_out/x2_out pass through the *_in signals combinationally.
  - In WAIT: they drive the held copies.
- Accept (IDLE, issue_valid=1, flush=0) latches cont, rd, x1, x2; cnt <= fpu_stall_in. Then by latency N = fpu_stall_in:
  - N=0: wb_data <= fpu_y, wb_rd <= rd_in, wb_valid <= 1 at the same edge; stay IDLE; no stall.
  - N>0: go WAIT. stall_out=1 combinationally during the accept cycle.
- WAIT:
  - cnt decrements each edge.
  - stall_out = (cnt != 1).
  - In the cycle with cnt==1, at the edge: wb_data <= fpu_y, wb_rd <= held rd, wb_valid <= 1, state <= IDLE.
  - Net effect: N stall cycles, instruction occupies EX for N+1 cycles, result captured N+1 edges after the accept edge's cycle begins.
- wb_valid is high exactly one cycle per completed instruction.
- wb_data/wb_rd hold their value until the next capture.
- issue_valid in WAIT is ignored: upstream is frozen, and the same instruction is still presented.
- Flush:
  - In IDLE it blocks accept.
  - In WAIT it returns to IDLE at the next edge, with no wb_valid and no capture.
  - stall_out is forced 0 combinationally in any cycle where flush=1.
  - Flush coinciding with the cnt==1 cycle: flush wins, no wb_valid.
- Back-to-back: the instruction after a completing one can be accepted in the cycle directly following the wb_valid edge. No bubble is required by this block.
- Async reset during WAIT: immediate IDLE; the in-flight result is discarded.
- Latencies above 6 are legal up to 2^CNT_W−1 and handled identically.

Test Plan:
- Reset, then issue fadd (cont 10000, stall 4, x1=0x3F800000, x2=0x40000000, rd=3); model fpu_y=0x40400000 valid from 4th cycle after accept -> stall_out high exactly 4 cycles; wb_valid pulse at accept+5th edge with wb_data 0x40400000, wb_rd 3; fpu_cont_out/x1_out/x2_out stable throughout while x1_in is toggled.
- Issue fsgnj (cont 11000, stall 0, rd=7), fpu_y=0xBF800000 -> no stall; wb_valid at the accept edge, wb_data 0xBF800000, wb_rd 7.
- Issue fdiv (stall 6), assert flush in 3rd WAIT cycle -> stall_out low that cycle, IDLE next edge, no wb_valid, wb_data keeps its previous value.
- fmul (stall 4, rd=1) followed immediately by fcvtsw (stall 1, rd=2) -> two wb_valid pulses separated by exactly 2 cycles; total stall cycles 5.
- Assert rstn low mid-WAIT of fsqrt (stall 2) -> busy, stall_out, wb_valid 0 immediately; after release a new fadd completes normally.
- Flush asserted in the cnt==1 cycle of fadd -> no wb_valid, state IDLE.
